// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR generator stream.
// It hunts for lock by re-seeding from the received bytes, then flywheels and counts errors.
module lfsr_checker #(
    parameter logic [7:0] TAPS       = 8'hB8,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 3,
    parameter int         CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);

    // state  | meaning
    // HUNT   | seeding from received data, counting consecutive correct predictions
    // LOCKED | flywheel on own prediction, flagging and counting mismatches
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_COUNT);

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], ^(x & TAPS)};
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic             pred_valid_q, pred_valid_d;
    logic [3:0]       match_run_q, match_run_d;
    logic [3:0]       miss_run_q, miss_run_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;

    logic       hit;
    logic       err_inc;
    logic       smp_inc;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    assign hit       = (data_in == pred_q);
    assign match_inc = match_run_q + 4'd1;
    assign miss_inc  = miss_run_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        pred_d         = pred_q;
        pred_valid_d   = pred_valid_q;
        match_run_d    = match_run_q;
        miss_run_d     = miss_run_q;
        err_pulse_d    = 1'b0;
        err_inc        = 1'b0;
        smp_inc        = 1'b0;

        if (data_valid) begin
            case (state_q)
                HUNT: begin
                    // 0x00 is the lock-up state: never a seed, never a match
                    pred_d       = lfsr_next(data_in);
                    pred_valid_d = (data_in != 8'h00);
                    if (pred_valid_q && hit && (data_in != 8'h00)) begin
                        match_run_d = match_inc;
                        if (match_inc == LOCK_RUN) begin
                            state_d    = LOCKED;
                            miss_run_d = 4'd0;
                        end
                    end else begin
                        match_run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    pred_d  = lfsr_next(pred_q);
                    smp_inc = 1'b1;
                    if (hit) begin
                        miss_run_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        miss_run_d  = miss_inc;
                        if (miss_inc == LOSS_RUN) begin
                            state_d      = HUNT;
                            pred_valid_d = 1'b0;
                            match_run_d  = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // clear wins over a same-cycle increment; counters hold at all-ones
    always_comb begin
        err_count_d    = err_count_q;
        sample_count_d = sample_count_q;
        if (clear) begin
            err_count_d    = '0;
            sample_count_d = '0;
        end else begin
            if (err_inc && (err_count_q != '1))
                err_count_d = err_count_q + CNT_W'(1);
            if (smp_inc && (sample_count_q != '1))
                sample_count_d = sample_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= HUNT;
            pred_q         <= 8'h00;
            pred_valid_q   <= 1'b0;
            match_run_q    <= 4'd0;
            miss_run_q     <= 4'd0;
            err_pulse_q    <= 1'b0;
            err_count_q    <= '0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            pred_q         <= pred_d;
            pred_valid_q   <= pred_valid_d;
            match_run_q    <= match_run_d;
            miss_run_q     <= miss_run_d;
            err_pulse_q    <= err_pulse_d;
            err_count_q    <= err_count_d;
            sample_count_q <= sample_count_d;
        end
    end

    assign locked       = (state_q == LOCKED);
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: table of sample vectors with hand-computed expectations,
// checked through a scoreboard queue, plus async-reset and HUNT rejection sequences.
module tb_lfsr_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        data_valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] sample_count;

    lfsr_checker #(
        .TAPS       (8'hB8),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3),
        .CNT_W      (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .clear        (clear),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sample_count (sample_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        clr;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [15:0] sc;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic clr,
                                input logic lk, input logic ep,
                                input logic [15:0] ec, input logic [15:0] sc);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.lk = lk; r.ep = ep; r.ec = ec; r.sc = sc;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t e);
        n_vec++;
        check("locked",       idx, {15'd0, locked},    {15'd0, e.lk});
        check("err_pulse",    idx, {15'd0, err_pulse}, {15'd0, e.ep});
        check("err_count",    idx, err_count,          e.ec);
        check("sample_count", idx, sample_count,       e.sc);
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        data_valid = v.v;
        data_in    = v.d;
        clear      = v.clr;
        sb_q.push_back(v);
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        clear      = 1'b0;
        e = sb_q.pop_front();
        check_all(idx, e);
    endtask

    initial begin
        // lock, flywheel, single error, gaps, clear+error, loss, relock, clear
        tbl.push_back(mk(1, 8'h0D, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h1B, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h36, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h6C, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hD8, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hB1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h62, 0, 1, 1, 1, 2));
        tbl.push_back(mk(1, 8'hC7, 0, 1, 0, 1, 3));
        tbl.push_back(mk(1, 8'h8F, 0, 1, 0, 1, 4));
        tbl.push_back(mk(0, 8'hFF, 0, 1, 0, 1, 4));
        tbl.push_back(mk(1, 8'h1E, 0, 1, 0, 1, 5));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 5));
        tbl.push_back(mk(0, 8'h55, 0, 1, 0, 1, 5));
        tbl.push_back(mk(1, 8'h3C, 0, 1, 0, 1, 6));
        tbl.push_back(mk(1, 8'h00, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hF3, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h00, 0, 1, 1, 1, 2));
        tbl.push_back(mk(1, 8'h00, 0, 1, 1, 2, 3));
        tbl.push_back(mk(1, 8'h00, 0, 0, 1, 3, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 8'h0D, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 8'h1B, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 8'h36, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 8'h6C, 0, 0, 0, 3, 4));
        tbl.push_back(mk(1, 8'hD8, 0, 1, 0, 3, 4));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hB1, 0, 1, 0, 0, 1));

        #1;
        check_all(-1, mk(0, 8'h00, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            apply(i, tbl[i]);

        // asynchronous reset while locked, off the clock edge
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_all(100, mk(0, 8'h00, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // zeros and a repeated seed must not advance the lock run
        apply(200, mk(1, 8'h00, 0, 0, 0, 0, 0));
        apply(201, mk(1, 8'h00, 0, 0, 0, 0, 0));
        apply(202, mk(1, 8'h0D, 0, 0, 0, 0, 0));
        apply(203, mk(1, 8'h0D, 0, 0, 0, 0, 0));
        apply(204, mk(1, 8'h1B, 0, 0, 0, 0, 0));
        apply(205, mk(1, 8'h36, 0, 0, 0, 0, 0));
        apply(206, mk(1, 8'h6C, 0, 0, 0, 0, 0));
        apply(207, mk(1, 8'hD8, 0, 1, 0, 0, 0));

        // one corrupted byte costs one error; continuation still matches
        apply(300, mk(1, 8'hB0, 0, 1, 1, 1, 1));
        apply(301, mk(1, 8'h63, 0, 1, 0, 1, 2));
        apply(302, mk(1, 8'hC7, 0, 1, 0, 1, 3));

        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
